// File: rtl/adder_sequencer_if.sv
// Control/memory-side bundle of the adder sequencer: host start/abort/ack in,
// memory read strobes and accumulator pipeline strobes out.
interface adder_sequencer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int CHANNELS   = 3
);
  localparam int CH_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  ADDER_SEQUENCER_Start_Routine;
  logic                  ADDER_SEQUENCER_Abort;
  logic                  ADDER_SEQUENCER_Routine_Finished_Already_Ok;
  logic                  ADDER_SEQUENCER_Mems_Re;
  logic [ADDR_WIDTH-1:0] ADDER_SEQUENCER_Mems_Addr;
  logic [CH_WIDTH-1:0]   ADDER_SEQUENCER_Channel;
  logic                  ADDER_SEQUENCER_Acc_Clr;
  logic                  ADDER_SEQUENCER_Acc_En;
  logic                  ADDER_SEQUENCER_Wr_En;
  logic                  ADDER_SEQUENCER_Busy;
  logic                  ADDER_SEQUENCER_Routine_Finished_Already;

  modport master (
    input  ADDER_SEQUENCER_Start_Routine, ADDER_SEQUENCER_Abort,
           ADDER_SEQUENCER_Routine_Finished_Already_Ok,
    output ADDER_SEQUENCER_Mems_Re, ADDER_SEQUENCER_Mems_Addr, ADDER_SEQUENCER_Channel,
           ADDER_SEQUENCER_Acc_Clr, ADDER_SEQUENCER_Acc_En, ADDER_SEQUENCER_Wr_En,
           ADDER_SEQUENCER_Busy, ADDER_SEQUENCER_Routine_Finished_Already
  );

  modport slave (
    output ADDER_SEQUENCER_Start_Routine, ADDER_SEQUENCER_Abort,
           ADDER_SEQUENCER_Routine_Finished_Already_Ok,
    input  ADDER_SEQUENCER_Mems_Re, ADDER_SEQUENCER_Mems_Addr, ADDER_SEQUENCER_Channel,
           ADDER_SEQUENCER_Acc_Clr, ADDER_SEQUENCER_Acc_En, ADDER_SEQUENCER_Wr_En,
           ADDER_SEQUENCER_Busy, ADDER_SEQUENCER_Routine_Finished_Already
  );
endinterface

// File: rtl/adder_sequencer.sv
// Sweeps CHANNELS*LENGTH feature-memory words, delays accumulator strobes by the
// memory read latency, then holds a finished flag until the host acknowledges.
module adder_sequencer #(
  parameter int LENGTH     = 784,
  parameter int CHANNELS   = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 2
) (
  input logic               ADDER_SEQUENCER_Clk,
  input logic               ADDER_SEQUENCER_Reset_InLow,
  adder_sequencer_if.master bus
);
  localparam int CH_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int W_WIDTH  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int D_WIDTH  = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam int TOTAL    = CHANNELS * LENGTH;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ      = 2'd1;
  localparam logic [1:0] DRAIN     = 2'd2;
  localparam logic [1:0] WAIT_CONF = 2'd3;

  logic clk, rst_n;
  logic start, abort, ok;
  assign clk   = ADDER_SEQUENCER_Clk;
  assign rst_n = ADDER_SEQUENCER_Reset_InLow;
  assign start = bus.ADDER_SEQUENCER_Start_Routine;
  assign abort = bus.ADDER_SEQUENCER_Abort;
  assign ok    = bus.ADDER_SEQUENCER_Routine_Finished_Already_Ok;

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [W_WIDTH-1:0]    word;
  logic [CH_WIDTH-1:0]   ch;
  logic [D_WIDTH-1:0]    drain_cnt;
  logic                  re, first, last, last_addr;
  logic [2:0]            tail;  // {valid, first, last} as seen by the datapath

  assign re        = (state == READ);
  assign first     = (word == '0);
  assign last      = (word == W_WIDTH'(LENGTH - 1));
  assign last_addr = (addr == ADDR_WIDTH'(TOTAL - 1));

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:      if (start) state_nxt = READ;
        READ:      if (last_addr) state_nxt = (RD_LATENCY == 0) ? WAIT_CONF : DRAIN;
        DRAIN:     if (drain_cnt <= D_WIDTH'(1)) state_nxt = WAIT_CONF;
        WAIT_CONF: if (ok) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      word      <= '0;
      ch        <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      // counters idle at zero so every routine starts from address 0
      if (state != READ) begin
        addr <= '0;
        word <= '0;
        ch   <= '0;
      end else if (!last_addr) begin
        addr <= addr + 1'b1;
        if (last) begin
          word <= '0;
          ch   <= ch + 1'b1;
        end else begin
          word <= word + 1'b1;
        end
      end
      if (state == READ) drain_cnt <= D_WIDTH'(RD_LATENCY);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_no_pipe
      assign tail = {re, re & first, re & last};
    end else begin : g_pipe
      logic [RD_LATENCY-1:0][2:0] vld_pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else if (abort) vld_pipe <= '0;
        else begin
          for (int i = RD_LATENCY - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
          vld_pipe[0] <= {re, re & first, re & last};
        end
      end
      assign tail = vld_pipe[RD_LATENCY-1];
    end
  endgenerate

  assign bus.ADDER_SEQUENCER_Mems_Re                 = re;
  assign bus.ADDER_SEQUENCER_Mems_Addr               = addr;
  assign bus.ADDER_SEQUENCER_Channel                 = ch;
  assign bus.ADDER_SEQUENCER_Acc_En                  = tail[2];
  assign bus.ADDER_SEQUENCER_Acc_Clr                 = tail[2] & tail[1];
  assign bus.ADDER_SEQUENCER_Wr_En                   = tail[2] & tail[0];
  assign bus.ADDER_SEQUENCER_Busy                    = (state == READ) || (state == DRAIN);
  assign bus.ADDER_SEQUENCER_Routine_Finished_Already = (state == WAIT_CONF);
endmodule

// File: tb/tb_adder_sequencer.sv
// Two sequencer configurations (4x2 words, latency 2; 1x3 words, latency 0)
// checked against directed vectors and a cycle-level routine model.
module tb_adder_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_sequencer_if #(.ADDR_WIDTH(8), .CHANNELS(2)) ia ();
  adder_sequencer_if #(.ADDR_WIDTH(8), .CHANNELS(3)) ib ();

  adder_sequencer #(.LENGTH(4), .CHANNELS(2), .ADDR_WIDTH(8), .RD_LATENCY(2)) dut_a (
    .ADDER_SEQUENCER_Clk(clk), .ADDER_SEQUENCER_Reset_InLow(rst_n), .bus(ia.master));
  adder_sequencer #(.LENGTH(1), .CHANNELS(3), .ADDR_WIDTH(8), .RD_LATENCY(0)) dut_b (
    .ADDER_SEQUENCER_Clk(clk), .ADDER_SEQUENCER_Reset_InLow(rst_n), .bus(ib.master));

  bit st[2], okk[2], ab[2];
  assign ia.ADDER_SEQUENCER_Start_Routine = st[0];
  assign ia.ADDER_SEQUENCER_Abort = ab[0];
  assign ia.ADDER_SEQUENCER_Routine_Finished_Already_Ok = okk[0];
  assign ib.ADDER_SEQUENCER_Start_Routine = st[1];
  assign ib.ADDER_SEQUENCER_Abort = ab[1];
  assign ib.ADDER_SEQUENCER_Routine_Finished_Already_Ok = okk[1];

  // observed vector: {re, addr, ch, en, clr, wr, busy, fin}; addr/ch only meaningful with re
  logic [17:0] obs[2];
  assign obs[0] = {ia.ADDER_SEQUENCER_Mems_Re,
                   ia.ADDER_SEQUENCER_Mems_Re ? ia.ADDER_SEQUENCER_Mems_Addr : 8'd0,
                   ia.ADDER_SEQUENCER_Mems_Re ? 4'(ia.ADDER_SEQUENCER_Channel) : 4'd0,
                   ia.ADDER_SEQUENCER_Acc_En, ia.ADDER_SEQUENCER_Acc_Clr, ia.ADDER_SEQUENCER_Wr_En,
                   ia.ADDER_SEQUENCER_Busy, ia.ADDER_SEQUENCER_Routine_Finished_Already};
  assign obs[1] = {ib.ADDER_SEQUENCER_Mems_Re,
                   ib.ADDER_SEQUENCER_Mems_Re ? ib.ADDER_SEQUENCER_Mems_Addr : 8'd0,
                   ib.ADDER_SEQUENCER_Mems_Re ? 4'(ib.ADDER_SEQUENCER_Channel) : 4'd0,
                   ib.ADDER_SEQUENCER_Acc_En, ib.ADDER_SEQUENCER_Acc_Clr, ib.ADDER_SEQUENCER_Wr_En,
                   ib.ADDER_SEQUENCER_Busy, ib.ADDER_SEQUENCER_Routine_Finished_Already};

  int checks = 0;
  int failures = 0;

  function automatic logic [17:0] mk(bit re, int addr, int ch, bit en, bit clr, bit wr,
                                     bit busy, bit fin);
    return {re, 8'(addr), 4'(ch), en, clr, wr, busy, fin};
  endfunction

  task automatic check(string name, logic [17:0] act, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b want %b (re|addr|ch|en|clr|wr|busy|fin)",
               name, $time, act, exp);
    end
  endtask

  function automatic int cfg_len(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int cfg_ch(int i);  return (i == 0) ? 2 : 3; endfunction
  function automatic int cfg_lat(int i); return (i == 0) ? 2 : 0; endfunction

  // Routine model: t counts cycles since the start was accepted. Reads occupy t<T,
  // data returns at t-lat, finished once t reaches T+lat.
  bit m_act[2] = '{0, 0};
  bit m_fin[2] = '{0, 0};
  int m_t[2]   = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_fin[i] <= 1'b0; m_t[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ab[i]) begin
          m_act[i] <= 1'b0; m_fin[i] <= 1'b0;
        end else if (m_act[i]) begin
          m_t[i] <= m_t[i] + 1;
          if (m_t[i] + 1 == cfg_len(i) * cfg_ch(i) + cfg_lat(i)) begin
            m_act[i] <= 1'b0; m_fin[i] <= 1'b1;
          end
        end else if (m_fin[i]) begin
          if (okk[i]) m_fin[i] <= 1'b0;
        end else if (st[i]) begin
          m_act[i] <= 1'b1; m_t[i] <= 0;
        end
      end
    end
  end

  function automatic logic [17:0] model_out(int i);
    int  tot = cfg_len(i) * cfg_ch(i);
    int  t   = m_t[i];
    int  j   = t - cfg_lat(i);
    bit  re  = m_act[i] && (t < tot);
    bit  en  = m_act[i] && (j >= 0) && (j < tot);
    bit  clr = en && (j % cfg_len(i) == 0);
    bit  wr  = en && (j % cfg_len(i) == cfg_len(i) - 1);
    return mk(re, re ? t : 0, re ? t / cfg_len(i) : 0, en, clr, wr, m_act[i], m_fin[i]);
  endfunction

  always @(negedge clk) begin
    check("model_a", obs[0], model_out(0));
    check("model_b", obs[1], model_out(1));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          start, ok, abort;
    logic [17:0] exp;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0)};
    tbl[1]  = '{0, 0, 0, mk(1, 1, 0, 0, 0, 0, 1, 0)};
    tbl[2]  = '{0, 0, 0, mk(1, 2, 0, 1, 1, 0, 1, 0)};
    tbl[3]  = '{0, 0, 0, mk(1, 3, 0, 1, 0, 0, 1, 0)};
    tbl[4]  = '{0, 0, 0, mk(1, 4, 1, 1, 0, 0, 1, 0)};
    tbl[5]  = '{0, 0, 0, mk(1, 5, 1, 1, 0, 1, 1, 0)};
    tbl[6]  = '{0, 0, 0, mk(1, 6, 1, 1, 1, 0, 1, 0)};
    tbl[7]  = '{0, 0, 0, mk(1, 7, 1, 1, 0, 0, 1, 0)};
    tbl[8]  = '{0, 0, 0, mk(0, 0, 0, 1, 0, 0, 1, 0)};
    tbl[9]  = '{0, 0, 0, mk(0, 0, 0, 1, 0, 1, 1, 0)};
    tbl[10] = '{0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};

    rst_n = 1'b0;
    #12;
    check("reset_a", obs[0], 18'd0);
    check("reset_b", obs[1], 18'd0);
    rst_n = 1'b1;
    step();

    // full routine on the 4x2 configuration
    for (int k = 0; k < 13; k++) begin
      st[0] = tbl[k].start; okk[0] = tbl[k].ok; ab[0] = tbl[k].abort;
      step();
      check($sformatf("vec%0d", k), obs[0], tbl[k].exp);
    end
    st[0] = 0; okk[0] = 0; ab[0] = 0;

    // latency 0, one word per channel: every read is its own first and last
    st[1] = 1; step(); st[1] = 0;
    check("lat0_w0", obs[1], mk(1, 0, 0, 1, 1, 1, 1, 0));
    step(); check("lat0_w1", obs[1], mk(1, 1, 1, 1, 1, 1, 1, 0));
    step(); check("lat0_w2", obs[1], mk(1, 2, 2, 1, 1, 1, 1, 0));
    step(); check("lat0_fin", obs[1], mk(0, 0, 0, 0, 0, 0, 0, 1));
    okk[1] = 1; step(); okk[1] = 0;
    check("lat0_ack", obs[1], 18'd0);

    // start pulses during READ and WAIT_CONF must not restart; no ack holds finish
    st[0] = 1; step(); st[0] = 0; step();
    st[0] = 1; step(); st[0] = 0;
    check("start_in_read", obs[0], mk(1, 2, 0, 1, 1, 0, 1, 0));
    repeat (8) step();
    check("fin_reached", obs[0], mk(0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 20; k++) begin
      st[0] = (k % 5 == 0);
      step();
      check("fin_hold", obs[0], mk(0, 0, 0, 0, 0, 0, 0, 1));
    end
    st[0] = 1; okk[0] = 1; step(); st[0] = 0; okk[0] = 0;
    check("start_ok_idle", obs[0], 18'd0);
    step(); check("no_restart", obs[0], 18'd0);

    // abort in the third READ cycle flushes the pipeline
    st[0] = 1; step(); st[0] = 0; step(); step();
    ab[0] = 1; step(); ab[0] = 0;
    check("abort_idle", obs[0], 18'd0);
    repeat (4) begin step(); check("abort_quiet", obs[0], 18'd0); end
    st[0] = 1; step(); st[0] = 0;
    check("restart_addr0", obs[0], mk(1, 0, 0, 0, 0, 0, 1, 0));

    // asynchronous reset while draining
    repeat (8) step();
    check("in_drain", obs[0], mk(0, 0, 0, 1, 0, 0, 1, 0));
    #2 rst_n = 1'b0;
    #1 check("async_rst_a", obs[0], 18'd0);
    check("async_rst_b", obs[1], 18'd0);
    #3 rst_n = 1'b1;
    repeat (12) begin step(); check("post_rst_idle", obs[0], 18'd0); end
    st[0] = 1; step(); st[0] = 0;
    repeat (10) step();
    check("post_rst_fin", obs[0], mk(0, 0, 0, 0, 0, 0, 0, 1));
    okk[0] = 1; step(); okk[0] = 0;

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        st[i]  = ($urandom % 8) == 0;
        okk[i] = ($urandom % 5) == 0;
        ab[i]  = ($urandom % 80) == 0;
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin st[i] = 0; okk[i] = 0; ab[i] = 0; end
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
